// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: PC width, predictor index slice and
// the branch resolve queue entry layout.
package bp_pkg;

  localparam int PC_W       = 32;
  localparam int PRED_IDX_W = 10;
  localparam int PC_IDX_HI  = 11;
  localparam int PC_IDX_LO  = 2;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            pred;
  } brq_entry_t;

  // Word-aligned PC bits that select a 2-bit counter in the predictor table.
  function automatic logic [PRED_IDX_W-1:0] pc_index(input logic [PC_W-1:0] pc);
    return pc[PC_IDX_HI:PC_IDX_LO];
  endfunction

endpackage

// File: rtl/brq_ptr.sv
// Wrap-around queue pointer with increment enable and synchronous load.
// Width is log2 of the queue depth, so the natural binary overflow is the wrap.
module brq_ptr #(
  parameter int PTR_W = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             inc_en,
  input  logic             load_en,
  input  logic [PTR_W-1:0] load_val,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // A load (flush) takes priority over a plain increment.
  always_comb begin
    ptr_d = ptr_q;
    if (load_en)
      ptr_d = load_val;
    else if (inc_en)
      ptr_d = ptr_q + PTR_W'(1);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      ptr_q <= '0;
    else
      ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order branch resolve queue feeding predictor-table updates and flushes.
// Optional BRQ_STATS_EN adds saturating resolve/mispredict counters.
module branch_resolve_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              alloc_valid,
  input  logic [PC_W-1:0]   alloc_pc,
  input  logic              alloc_pred,
  output logic              alloc_ready,
  input  logic              resolve_valid,
  input  logic              resolve_taken,
  output logic              isBranch,
  output logic              isTaken,
  output logic [PC_W-1:0]   InstrPC,
  output logic              mispredict,
  output logic [PC_W-1:0]   mispredict_pc,
  output logic              underflow,
`ifdef BRQ_STATS_EN
  output logic [31:0]       stat_resolved,
  output logic [31:0]       stat_mispred,
`endif
  output logic [PTR_W:0]    count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  brq_entry_t mem [DEPTH];

  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [PTR_W-1:0] head_next;

  logic [PTR_W:0]   count_q, count_d;
  logic             is_branch_q, is_branch_d;
  logic             is_taken_q, is_taken_d;
  logic [PC_W-1:0]  instr_pc_q, instr_pc_d;
  logic             mispredict_q, mispredict_d;
  logic [PC_W-1:0]  mispredict_pc_q, mispredict_pc_d;
  logic             underflow_q, underflow_d;

  logic       alloc_fire;
  logic       resolve_fire;
  logic       flush;
  logic       alloc_take;
  brq_entry_t head_entry;

  assign alloc_ready  = (count_q != FULL_CNT);
  assign alloc_fire   = alloc_valid & alloc_ready;
  assign resolve_fire = resolve_valid & (count_q != '0);
  assign head_entry   = mem[head_ptr];
  assign flush        = resolve_fire & (resolve_taken != head_entry.pred);
  assign alloc_take   = alloc_fire & ~flush;
  assign head_next    = head_ptr + PTR_W'(1);

  brq_ptr #(.PTR_W(PTR_W)) u_head (
    .CLK      (CLK),
    .RESET    (RESET),
    .inc_en   (resolve_fire),
    .load_en  (1'b0),
    .load_val ('0),
    .ptr      (head_ptr)
  );

  // On a flush the tail collapses onto the slot after the mispredicted branch,
  // which is exactly where head lands, leaving the queue empty.
  brq_ptr #(.PTR_W(PTR_W)) u_tail (
    .CLK      (CLK),
    .RESET    (RESET),
    .inc_en   (alloc_take),
    .load_en  (flush),
    .load_val (head_next),
    .ptr      (tail_ptr)
  );

  always_ff @(posedge CLK) begin
    if (alloc_take)
      mem[tail_ptr] <= '{pc: alloc_pc, pred: alloc_pred};
  end

  always_comb begin
    count_d         = count_q;
    is_branch_d     = 1'b0;
    is_taken_d      = is_taken_q;
    instr_pc_d      = instr_pc_q;
    mispredict_d    = 1'b0;
    mispredict_pc_d = mispredict_pc_q;
    underflow_d     = resolve_valid & (count_q == '0);

    if (flush)
      count_d = '0;
    else if (alloc_take && !resolve_fire)
      count_d = count_q + (PTR_W+1)'(1);
    else if (!alloc_take && resolve_fire)
      count_d = count_q - (PTR_W+1)'(1);

    if (resolve_fire) begin
      is_branch_d     = 1'b1;
      is_taken_d      = resolve_taken;
      instr_pc_d      = head_entry.pc;
      mispredict_d    = flush;
      mispredict_pc_d = head_entry.pc;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count_q         <= '0;
      is_branch_q     <= 1'b0;
      is_taken_q      <= 1'b0;
      instr_pc_q      <= '0;
      mispredict_q    <= 1'b0;
      mispredict_pc_q <= '0;
      underflow_q     <= 1'b0;
    end else begin
      count_q         <= count_d;
      is_branch_q     <= is_branch_d;
      is_taken_q      <= is_taken_d;
      instr_pc_q      <= instr_pc_d;
      mispredict_q    <= mispredict_d;
      mispredict_pc_q <= mispredict_pc_d;
      underflow_q     <= underflow_d;
    end
  end

  assign count         = count_q;
  assign isBranch      = is_branch_q;
  assign isTaken       = is_taken_q;
  assign InstrPC       = instr_pc_q;
  assign mispredict    = mispredict_q;
  assign mispredict_pc = mispredict_pc_q;
  assign underflow     = underflow_q;

`ifdef BRQ_STATS_EN
  logic [31:0] stat_resolved_q, stat_resolved_d;
  logic [31:0] stat_mispred_q, stat_mispred_d;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    stat_resolved_d = stat_resolved_q;
    stat_mispred_d  = stat_mispred_q;
    if (resolve_fire && stat_resolved_q != 32'hFFFF_FFFF)
      stat_resolved_d = stat_resolved_q + 32'd1;
    if (flush && stat_mispred_q != 32'hFFFF_FFFF)
      stat_mispred_d = stat_mispred_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      stat_resolved_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_resolved_q <= stat_resolved_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_resolved = stat_resolved_q;
  assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized and directed bench for branch_resolve_queue against a queue-based
// reference model. Define BRQ_STATS_EN to also check the statistics counters.
module tb_branch_resolve_queue;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic        CLK;
  logic        RESET;
  logic        alloc_valid;
  logic [31:0] alloc_pc;
  logic        alloc_pred;
  logic        alloc_ready;
  logic        resolve_valid;
  logic        resolve_taken;
  logic        isBranch;
  logic        isTaken;
  logic [31:0] InstrPC;
  logic        mispredict;
  logic [31:0] mispredict_pc;
  logic        underflow;
  logic [PTR_W:0] count;
`ifdef BRQ_STATS_EN
  logic [31:0] stat_resolved;
  logic [31:0] stat_mispred;
`endif

  branch_resolve_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .alloc_valid   (alloc_valid),
    .alloc_pc      (alloc_pc),
    .alloc_pred    (alloc_pred),
    .alloc_ready   (alloc_ready),
    .resolve_valid (resolve_valid),
    .resolve_taken (resolve_taken),
    .isBranch      (isBranch),
    .isTaken       (isTaken),
    .InstrPC       (InstrPC),
    .mispredict    (mispredict),
    .mispredict_pc (mispredict_pc),
    .underflow     (underflow),
`ifdef BRQ_STATS_EN
    .stat_resolved (stat_resolved),
    .stat_mispred  (stat_mispred),
`endif
    .count         (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of {pc, pred}, oldest at the front.
  logic [32:0] model_q [$];
  logic        exp_branch, exp_taken, exp_mis, exp_under;
  logic [31:0] exp_pc, exp_mpc;
  int          exp_res_cnt, exp_mis_cnt;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic modelReset();
    model_q.delete();
    exp_branch  = 1'b0;
    exp_taken   = 1'b0;
    exp_pc      = '0;
    exp_mis     = 1'b0;
    exp_mpc     = '0;
    exp_under   = 1'b0;
    exp_res_cnt = 0;
    exp_mis_cnt = 0;
  endtask

  task automatic checkAll();
    checkOutput("count", 32'(count), 32'(model_q.size()));
    checkOutput("isBranch", 32'(isBranch), 32'(exp_branch));
    checkOutput("isTaken", 32'(isTaken), 32'(exp_taken));
    checkOutput("InstrPC", InstrPC, exp_pc);
    checkOutput("mispredict", 32'(mispredict), 32'(exp_mis));
    checkOutput("mispredict_pc", mispredict_pc, exp_mpc);
    checkOutput("underflow", 32'(underflow), 32'(exp_under));
`ifdef BRQ_STATS_EN
    checkOutput("stat_resolved", stat_resolved, 32'(exp_res_cnt));
    checkOutput("stat_mispred", stat_mispred, 32'(exp_mis_cnt));
`endif
  endtask

  // Drive one cycle of inputs, predict the edge's effect, then check after it.
  task automatic applyStimulus(input logic av, input logic [31:0] apc, input logic ap,
                               input logic rv, input logic rt);
    logic        room;
    logic [32:0] e;
    alloc_valid   = av;
    alloc_pc      = apc;
    alloc_pred    = ap;
    resolve_valid = rv;
    resolve_taken = rt;
    room = (model_q.size() < DEPTH);
    #1;
    checkOutput("alloc_ready", 32'(alloc_ready), 32'(room));

    exp_branch = 1'b0;
    exp_mis    = 1'b0;
    exp_under  = 1'b0;
    if (rv && model_q.size() > 0) begin
      e = model_q.pop_front();
      exp_branch = 1'b1;
      exp_taken  = rt;
      exp_pc     = e[32:1];
      exp_mpc    = e[32:1];
      exp_mis    = (rt != e[0]);
      exp_res_cnt++;
      if (exp_mis) begin
        exp_mis_cnt++;
        model_q.delete();
      end else if (av && room) begin
        model_q.push_back({apc, ap});
      end
    end else begin
      exp_under = rv;
      if (av && room) model_q.push_back({apc, ap});
    end

    @(posedge CLK);
    #1;
    checkAll();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    alloc_valid   = 1'b0;
    alloc_pc      = '0;
    alloc_pred    = 1'b0;
    resolve_valid = 1'b0;
    resolve_taken = 1'b0;
    RESET         = 1'b0;
    modelReset();
    #12;
    checkAll();
    checkOutput("reset alloc_ready", 32'(alloc_ready), 32'd1);
    RESET = 1'b1;
    @(posedge CLK);
    #1;

    // Fill and drain
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, 32'h100 + 32'(4*i), 1'b1, 1'b0, 1'b0);
    checkOutput("fill count", 32'(count), 32'd8);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      checkOutput("drain pc", InstrPC, 32'h100 + 32'(4*i));
    end

    // Mispredict flush, then resolve on an empty queue
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h204, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h208, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h20C, 1'b1, 1'b1, 1'b1);
    checkOutput("flush mispredict", 32'(mispredict), 32'd1);
    checkOutput("flush mpc", mispredict_pc, 32'h200);
    checkOutput("flush count", 32'(count), 32'd0);
    idle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("underflow pulse", 32'(underflow), 32'd1);

    // Simultaneous allocate and resolve at count 3
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'h2F0 + 32'(4*i), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h300, 1'b0, 1'b1, 1'b1);
    checkOutput("simul count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, (i == 2) ? 1'b0 : 1'b1);
    checkOutput("simul order", InstrPC, 32'h300);

    // Full queue: allocation ignored even with a same-cycle resolve
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, 32'h400 + 32'(4*i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h4F0, 1'b0, 1'b1, 1'b0);
    checkOutput("full count", 32'(count), 32'd7);
    for (int i = 0; i < 7; i++)
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Wrap-around with alternating allocate/resolve
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) applyStimulus(1'b1, 32'h500 + 32'(4*i), 1'b1, 1'b0, 1'b0);
      else            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    end

    // Asynchronous reset with 5 entries queued and a strobe in flight
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 32'h600 + 32'(4*i), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    #2;
    RESET = 1'b0;
    #1;
    modelReset();
    checkOutput("async count", 32'(count), 32'd0);
    checkOutput("async isBranch", 32'(isBranch), 32'd0);
    checkOutput("async alloc_ready", 32'(alloc_ready), 32'd1);
    checkAll();
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                    1'($urandom), ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0));
    end

`ifdef BRQ_STATS_EN
    // Ten resolves, three of them mispredicted, from a fresh reset
    RESET = 1'b0;
    #2;
    modelReset();
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'h700 + 32'(4*i), 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, (i % 3 == 0) && (i < 9) ? 1'b0 : 1'b1);
    end
    checkOutput("stats resolved", stat_resolved, 32'd10);
    checkOutput("stats mispred", stat_mispred, 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- In-order queue between fetch and the 2-bit saturating-counter predictor table.
- Fetch allocates one entry per predicted branch, holding the PC and the predicted direction.
- Execute resolves branches oldest-first; the block compares actual against predicted and drives the one-cycle update strobe (isBranch/isTaken/InstrPC) into the predictor table.
- On a mispredict it raises a flush and discards all younger entries.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 2.
- PTR_W, 3, pointer width; equals log2(DEPTH).

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- alloc_valid  input  1  fetch presents a predicted branch this cycle.
- alloc_pc  input  32  PC of the allocated branch.
- alloc_pred  input  1  predicted direction, 1 = taken.
- alloc_ready  output  1  queue not full; combinational from count only.
- resolve_valid  input  1  execute resolves the oldest outstanding branch.
- resolve_taken  input  1  actual direction.
- isBranch  output  1  registered update strobe to the predictor table.
- isTaken  output  1  registered actual direction.
- InstrPC  output  32  registered PC of the resolved branch.
- mispredict  output  1  registered one-cycle flush pulse.
- mispredict_pc  output  32  PC of the mispredicted branch.
- underflow  output  1  registered pulse: resolve_valid arrived with the queue empty.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: circular buffer of {pc[31:0], pred}; head = oldest, tail = next free slot; separate count register.
- Allocate fires when alloc_valid & alloc_ready: write at tail, tail+1 with wrap mod DEPTH, count+1.
- Resolve fires when resolve_valid & count != 0: read head, head+1 with wrap, count-1.
- Next edge after a resolve fire:
  - isBranch=1, isTaken=resolve_taken, InstrPC=entry pc.
  - mispredict = (resolve_taken != entry pred); mispredict_pc = entry pc.
  - Latency is exactly 1 cycle from resolve fire to strobe.
- Cycles with no resolve fire: isBranch=0 and mispredict=0; InstrPC, isTaken and mispredict_pc hold their last values.
- Simultaneous allocate and resolve, no mispredict: both take effect; count unchanged.
- Full queue: alloc_ready=0; alloc_valid is ignored even if a resolve fires the same cycle (no bypass).
- Mispredict flush, applied in the same edge as the resolve fire:
  - tail := head+1 (wrap), count := 0.
  - A same-cycle allocate is dropped because it is younger than the branch.
- Empty-queue resolve: no state change, isBranch=0, underflow=1 for one cycle.
- Reset values: head=0, tail=0, count=0, isBranch=0, isTaken=0, InstrPC=0, mispredict=0, mispredict_pc=0, underflow=0; entry storage is not reset.
- Reset asserted mid-operation clears all outstanding entries and outputs immediately (asynchronous).
- No state machine beyond the pointers and count; fill state is fully determined by count.

Optional Feature:
- Macro BRQ_STATS_EN.
- Defined: adds output ports stat_resolved[31:0] and stat_mispred[31:0].
  - Both reset to 0.
  - stat_resolved increments on each resolve fire; stat_mispred increments on each mispredict.
  - Both saturate at 32'hFFFFFFFF; no wrap.
- Not defined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package bp_pkg: PC_W=32, PRED_IDX_W=10, the PC index slice constants (bits 11:2), and the entry struct {pc, pred}.
- One natural sub-module: brq_ptr, a wrap-around pointer with an increment enable and a synchronous load (the load is used for the flush); instantiated twice, for head and tail.

Test Plan:
- Fill and drain:
  - Allocate PCs 0x100, 0x104, … 0x11C with pred=1: count reaches 8 and alloc_ready=0.
  - Resolve 8 times taken: isBranch pulses with InstrPC 0x100..0x11C in order, mispredict never asserts, count returns to 0.
- Mispredict flush:
  - Allocate 0x200 (pred=0), 0x204, 0x208; resolve taken.
  - Next cycle: mispredict=1, mispredict_pc=0x200, isTaken=1, count=0.
  - A later resolve produces underflow=1.
- Simultaneous allocate and resolve:
  - At count=3, allocate 0x300 while resolving correctly: count stays 3.
  - 0x300 appears after the two remaining older entries drain.
- Full-queue boundary: at count=8, alloc_valid=1 with resolve_valid=1 → allocation is ignored and count=7.
- Wrap-around: 20 alternating allocate/resolve cycles → FIFO order preserved across the pointer wrap; InstrPC matches the allocated sequence.
- Asynchronous reset with 5 entries queued: drop RESET between clock edges → count=0, isBranch=0, alloc_ready=1 without waiting for a clock edge.
- BRQ_STATS_EN build: 10 resolves with 3 mispredicts → stat_resolved=10, stat_mispred=3.
